hs_skid_buffer: RTL

HS_SKID_BUFFER -- requirements
Module: hs_skid_buffer

---
 rtl/hs_skid_buffer.sv | 99 +++++++++
 1 files changed

// File: rtl/hs_skid_buffer.sv
// Two-entry valid/ready skid buffer with fully registered outputs (s_ready, m_valid, m_data).
// Optional downstream transfer counter: define HS_SKID_CNT_EN to add the 16-bit xfer_cnt port.
module hs_skid_buffer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
`ifdef HS_SKID_CNT_EN
  ,
  output logic [15:0]       xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] skid;
  logic [DATA_W-1:0] main_next;
  logic [DATA_W-1:0] skid_next;
  logic              s_fire;
  logic              m_fire;

  assign s_fire = s_valid && s_ready;
  assign m_fire = m_valid && m_ready;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    main_next  = m_data;
    skid_next  = skid;
    unique case (state)
      EMPTY: begin
        if (s_fire) begin
          main_next  = s_data;
          state_next = ONE;
        end
      end
      ONE: begin
        if (s_fire && m_fire) begin
          main_next = s_data;
        end else if (s_fire) begin
          skid_next  = s_data;
          state_next = FULL;
        end else if (m_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        // s_ready is low here, so only a drain can happen.
        if (m_fire) begin
          main_next  = skid;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the payload registers are cleared too, so no stale word is visible after reset.
      state   <= EMPTY;
      m_data  <= '0;
      skid    <= '0;
      m_valid <= 1'b0;
      s_ready <= 1'b0;
    end else begin
      state   <= state_next;
      m_data  <= main_next;
      skid    <= skid_next;
      // Handshake outputs come from the next state, keeping m_ready off any combinational path.
      m_valid <= (state_next != EMPTY);
      s_ready <= (state_next != FULL);
    end
  end

`ifdef HS_SKID_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt <= 16'd0;
    end else if (m_fire) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule
